loas_inner_join_multi: RTL and testbench
========================================

Name: loas_inner_join_multi

Overview:
- Next-generation LoAS inner-join stage.
- Compares one spike pattern against PARALLEL_FACTOR weight patterns per batch and builds a hit mask from popcount(AND) >= threshold.
- Emits every hit lane, in ascending lane order, over a valid/ready stream; a first-hit-only mode is also available.
- Sits between the weight fetch stage and the TPPE accumulation FIFO. Input and output carry full handshakes, and per-batch statistics counters are included.

Parameters:
- T_WINDOW, 16, spike/weight pattern length in timesteps.
- PARALLEL_FACTOR, 8, weight lanes compared per batch (>=1).
- NEURON_ID_W, 4, neuron id width.
- COL_ID_W, 6, column id width.
- SCORE_W, $clog2(T_WINDOW+1), match score width.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  batch present.
- in_ready  out  1  block can accept a batch.
- in_neuron  in  NEURON_ID_W  neuron id of batch.
- in_col_base  in  COL_ID_W  column id of lane 0.
- in_spike  in  T_WINDOW  spike pattern.
- in_weights  in  PARALLEL_FACTOR*T_WINDOW  lane k at [k*T_WINDOW +: T_WINDOW].
- in_threshold  in  SCORE_W  minimum score for a hit.
- in_first_only  in  1  1 = emit only the lowest hit lane.
- out_valid  out  1  hit record present.
- out_ready  in  1  consumer accepts.
- out_neuron  out  NEURON_ID_W  neuron id.
- out_col  out  COL_ID_W  col_base + lane, mod 2^COL_ID_W.
- out_score  out  SCORE_W  popcount(spike & weight).
- out_last  out  1  final record of this batch.
- stat_batches  out  CNT_W  batches accepted.
- stat_hits  out  CNT_W  records emitted.
- stat_empty  out  CNT_W  batches with zero hits (dropped).

Behaviour:
- Reset (rst=1, asynchronous):
  - state IDLE; pending mask, score regs and all stat counters = 0.
  - in_ready=1; out_valid=0; out_neuron/out_col/out_score/out_last = 0.
- States: IDLE and EMIT.
- in_ready = (state==IDLE). Accept occurs on a rising edge with in_valid & in_ready.
- On accept, the following are captured in registers:
  - neuron, col_base, all lane scores;
  - mask[k] = (score_k >= in_threshold);
  - if in_first_only, only the lowest set bit of the mask is kept.
- Score arithmetic: score_k is the full-width popcount, never truncated. A threshold of 0 makes every lane a hit.
- After accept:
  - mask==0: stay IDLE, stat_empty++, no output record.
  - mask!=0: go to EMIT. out_valid is high in the cycle after accept (latency 1).
- In EMIT, outputs are driven from registers:
  - lane L = lowest set bit of the pending mask;
  - out_col = col_base + L;
  - out_score = score_L;
  - out_last = (pending has exactly one bit set).
- out_valid & out_ready: clear bit L and stat_hits++. If out_last, return to IDLE; in_ready is 1 the next cycle.
- out_ready low: all out_* stay stable and out_valid stays high (no retraction).
- Throughput: one record per cycle while out_ready=1. A batch with H hits occupies H cycles in EMIT plus 1 accept cycle.
- stat_batches increments on every accept.
- All stat counters saturate at 2^CNT_W-1.
- in_* are ignored while in EMIT.
- Reset asserted mid-EMIT discards pending records immediately. No out_valid appears after release until a new batch is accepted.

Test Plan:
- Single hit, PF=8, T=16:
  - Stimulus: spike=16'h00FF; lane3 weight=16'h000F, other lanes 0; thr=4; col_base=10; neuron=5.
  - Response: one cycle after accept, out_valid=1, out_col=13, out_score=4, out_neuron=5, out_last=1.
  - stat_batches=1, stat_hits=1.
- Multi-hit ordering:
  - Stimulus: lanes 1, 4, 6 hit with scores 5, 8, 6; out_ready held 1.
  - Response: records col_base+1, +4, +6 on consecutive cycles; out_last=1 only on +6; in_ready=1 the following cycle.
- First-only mode:
  - Stimulus: same batch with in_first_only=1.
  - Response: exactly one record, lane 1, out_last=1.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles during a 3-hit batch.
  - Response: out_valid and all out_* fields stable throughout the stall; all 3 records delivered after release; in_ready=0 throughout.
- Empty batch and wrap-around:
  - Empty batch: thr=17 → no out_valid, stat_empty=1, in_ready=1 the next cycle.
  - Wrap-around: col_base=62, COL_ID_W=6, lane 3 hit → out_col=1.
- Reset mid-EMIT:
  - Stimulus: pulse rst after the first of 3 records.
  - Response: out_valid=0 immediately, counters=0, in_ready=1, no residual records after release.

Source files
------------

// File: rtl/loas_inner_join_multi.sv
// LoAS inner-join stage: scores one spike pattern against PARALLEL_FACTOR weight lanes
// and streams every hit lane (or only the lowest one) as a record, lowest lane first.
module loas_inner_join_multi #(
    parameter int T_WINDOW        = 16,
    parameter int PARALLEL_FACTOR = 8,
    parameter int NEURON_ID_W     = 4,
    parameter int COL_ID_W        = 6,
    parameter int SCORE_W         = $clog2(T_WINDOW + 1),
    parameter int CNT_W           = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NEURON_ID_W-1:0]                in_neuron,
    input  logic [COL_ID_W-1:0]                   in_col_base,
    input  logic [T_WINDOW-1:0]                   in_spike,
    input  logic [PARALLEL_FACTOR*T_WINDOW-1:0]   in_weights,
    input  logic [SCORE_W-1:0]                    in_threshold,
    input  logic                                  in_first_only,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NEURON_ID_W-1:0]                out_neuron,
    output logic [COL_ID_W-1:0]                   out_col,
    output logic [SCORE_W-1:0]                    out_score,
    output logic                                  out_last,
    output logic [CNT_W-1:0]                      stat_batches,
    output logic [CNT_W-1:0]                      stat_hits,
    output logic [CNT_W-1:0]                      stat_empty
);

    localparam int PF     = PARALLEL_FACTOR;
    localparam int LANE_W = (PF > 1) ? $clog2(PF) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    function automatic logic [SCORE_W-1:0] popcount(input logic [T_WINDOW-1:0] v);
        logic [SCORE_W-1:0] sum;
        sum = {SCORE_W{1'b0}};
        for (int i = 0; i < T_WINDOW; i++) begin
            sum = sum + SCORE_W'(v[i]);
        end
        return sum;
    endfunction

    function automatic logic [LANE_W-1:0] lowest_lane(input logic [PF-1:0] m);
        logic [LANE_W-1:0] idx;
        idx = {LANE_W{1'b0}};
        for (int i = PF - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = LANE_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [PF-1:0] m);
        return (m != {PF{1'b0}}) && ((m & (m - PF'(1'b1))) == {PF{1'b0}});
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        logic [CNT_W-1:0] r;
        if (en && (c != {CNT_W{1'b1}})) begin
            r = c + CNT_W'(1'b1);
        end else begin
            r = c;
        end
        return r;
    endfunction

    state_t                          r_state;
    state_t                          w_state_next;
    logic [PF-1:0]                   r_pend;
    logic [PF-1:0]                   w_pend_next;
    logic [PF-1:0][SCORE_W-1:0]      r_score;
    logic [PF-1:0][SCORE_W-1:0]      w_score_next;
    logic [PF-1:0][SCORE_W-1:0]      w_score;
    logic [PF-1:0]                   w_hit;
    logic [PF-1:0]                   w_first;
    logic [PF-1:0]                   w_cur_bit;
    logic [NEURON_ID_W-1:0]          r_neuron;
    logic [NEURON_ID_W-1:0]          w_neuron_next;
    logic [COL_ID_W-1:0]             r_col_base;
    logic [COL_ID_W-1:0]             w_col_base_next;
    logic [LANE_W-1:0]               w_lane_next;
    logic                            w_accept;
    logic                            w_pop;
    logic                            w_batch_inc;
    logic                            w_hit_inc;
    logic                            w_empty_inc;

    logic                            r_in_ready;
    logic                            r_out_valid;
    logic [NEURON_ID_W-1:0]          r_out_neuron;
    logic [COL_ID_W-1:0]             r_out_col;
    logic [SCORE_W-1:0]              r_out_score;
    logic                            r_out_last;
    logic [CNT_W-1:0]                r_stat_batches;
    logic [CNT_W-1:0]                r_stat_hits;
    logic [CNT_W-1:0]                r_stat_empty;

    // Per-lane match scores and hit mask for the batch on the input port.
    always_comb begin
        w_score = {PF{ {SCORE_W{1'b0}} }};
        w_hit   = {PF{1'b0}};
        for (int k = 0; k < PF; k++) begin
            w_score[k] = popcount(in_spike & in_weights[k*T_WINDOW +: T_WINDOW]);
            w_hit[k]   = (w_score[k] >= in_threshold);
        end
    end

    assign w_first   = w_hit & (~w_hit + PF'(1'b1));
    assign w_cur_bit = r_pend & (~r_pend + PF'(1'b1));
    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_pop     = r_out_valid && out_ready;

    // Next-state, next pending mask and statistics strobes.
    always_comb begin
        w_state_next    = r_state;
        w_pend_next     = r_pend;
        w_score_next    = r_score;
        w_neuron_next   = r_neuron;
        w_col_base_next = r_col_base;
        w_batch_inc     = 1'b0;
        w_hit_inc       = 1'b0;
        w_empty_inc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_batch_inc     = 1'b1;
                    w_score_next    = w_score;
                    w_neuron_next   = in_neuron;
                    w_col_base_next = in_col_base;
                    w_pend_next     = in_first_only ? w_first : w_hit;
                    if (w_pend_next == {PF{1'b0}}) begin
                        w_empty_inc  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_EMIT;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_EMIT: begin
                if (w_pop) begin
                    w_hit_inc    = 1'b1;
                    w_pend_next  = r_pend & ~w_cur_bit;
                    w_state_next = r_out_last ? S_IDLE : S_EMIT;
                end else begin
                    w_state_next = S_EMIT;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_pend_next  = {PF{1'b0}};
            end
        endcase
    end

    assign w_lane_next = lowest_lane(w_pend_next);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Batch context, pending mask and the registered output record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend       <= {PF{1'b0}};
            r_score      <= {PF{ {SCORE_W{1'b0}} }};
            r_neuron     <= {NEURON_ID_W{1'b0}};
            r_col_base   <= {COL_ID_W{1'b0}};
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_neuron <= {NEURON_ID_W{1'b0}};
            r_out_col    <= {COL_ID_W{1'b0}};
            r_out_score  <= {SCORE_W{1'b0}};
            r_out_last   <= 1'b0;
        end else begin
            r_pend       <= w_pend_next;
            r_score      <= w_score_next;
            r_neuron     <= w_neuron_next;
            r_col_base   <= w_col_base_next;
            r_in_ready   <= (w_state_next == S_IDLE);
            r_out_valid  <= (w_state_next == S_EMIT);
            r_out_neuron <= w_neuron_next;
            r_out_col    <= w_col_base_next + COL_ID_W'(w_lane_next);
            r_out_score  <= w_score_next[w_lane_next];
            r_out_last   <= is_onehot(w_pend_next);
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_batches <= {CNT_W{1'b0}};
            r_stat_hits    <= {CNT_W{1'b0}};
            r_stat_empty   <= {CNT_W{1'b0}};
        end else begin
            r_stat_batches <= sat_inc(r_stat_batches, w_batch_inc);
            r_stat_hits    <= sat_inc(r_stat_hits, w_hit_inc);
            r_stat_empty   <= sat_inc(r_stat_empty, w_empty_inc);
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_neuron   = r_out_neuron;
    assign out_col      = r_out_col;
    assign out_score    = r_out_score;
    assign out_last     = r_out_last;
    assign stat_batches = r_stat_batches;
    assign stat_hits    = r_stat_hits;
    assign stat_empty   = r_stat_empty;

endmodule

// File: tb/tb_loas_inner_join_multi.sv
// Directed bench for loas_inner_join_multi with hand-computed expected records.
module tb_loas_inner_join_multi;

    localparam int T  = 16;
    localparam int PF = 8;
    localparam int SW = $clog2(T + 1);

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_neuron;
    logic [5:0]        in_col_base;
    logic [T-1:0]      in_spike;
    logic [PF*T-1:0]   in_weights;
    logic [SW-1:0]     in_threshold;
    logic              in_first_only;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_neuron;
    logic [5:0]        out_col;
    logic [SW-1:0]     out_score;
    logic              out_last;
    logic [15:0]       stat_batches;
    logic [15:0]       stat_hits;
    logic [15:0]       stat_empty;

    int checks = 0;
    int errors = 0;

    loas_inner_join_multi dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_neuron    (in_neuron),
        .in_col_base  (in_col_base),
        .in_spike     (in_spike),
        .in_weights   (in_weights),
        .in_threshold (in_threshold),
        .in_first_only(in_first_only),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_neuron   (out_neuron),
        .out_col      (out_col),
        .out_score    (out_score),
        .out_last     (out_last),
        .stat_batches (stat_batches),
        .stat_hits    (stat_hits),
        .stat_empty   (stat_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rec(input string tag, input int neu, input int col, input int score, input int last);
        chk({tag, "_valid"},  32'(out_valid),  32'd1);
        chk({tag, "_neuron"}, 32'(out_neuron), 32'(neu));
        chk({tag, "_col"},    32'(out_col),    32'(col));
        chk({tag, "_score"},  32'(out_score),  32'(score));
        chk({tag, "_last"},   32'(out_last),   32'(last));
    endtask

    task automatic drive(input int neu, input int colb, input logic [T-1:0] spk, input int thr, input logic first);
        in_neuron     = 4'(neu);
        in_col_base   = 6'(colb);
        in_spike      = spk;
        in_threshold  = SW'(thr);
        in_first_only = first;
    endtask

    // lanes 1,4,6 score 5,8,6 against an all-ones spike; other lanes score 3
    task automatic load_multi();
        for (int k = 0; k < PF; k++) in_weights[k*T +: T] = 16'h0007;
        in_weights[1*T +: T] = 16'h001F;
        in_weights[4*T +: T] = 16'h00FF;
        in_weights[6*T +: T] = 16'h003F;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_weights = '0;
        drive(0, 0, 16'h0000, 0, 1'b0);
        step(2);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_col", 32'(out_col), 32'd0);
        chk("rst_out_score", 32'(out_score), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_batches", 32'(stat_batches), 32'd0);
        rst = 1'b0;
        step(1);

        // single hit
        in_weights = '0;
        in_weights[3*T +: T] = 16'h000F;
        drive(5, 10, 16'h00FF, 4, 1'b0);
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        check_rec("single", 5, 13, 4, 1);
        chk("single_in_ready", 32'(in_ready), 32'd0);
        chk("single_batches", 32'(stat_batches), 32'd1);
        step(1);
        chk("single_done_valid", 32'(out_valid), 32'd0);
        chk("single_done_ready", 32'(in_ready), 32'd1);
        chk("single_hits", 32'(stat_hits), 32'd1);

        // multi-hit ordering
        load_multi();
        drive(2, 20, 16'hFFFF, 5, 1'b0);
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        check_rec("multi0", 2, 21, 5, 0);
        step(1);
        check_rec("multi1", 2, 24, 8, 0);
        step(1);
        check_rec("multi2", 2, 26, 6, 1);
        chk("multi2_in_ready", 32'(in_ready), 32'd0);
        step(1);
        chk("multi_done_valid", 32'(out_valid), 32'd0);
        chk("multi_done_ready", 32'(in_ready), 32'd1);
        chk("multi_hits", 32'(stat_hits), 32'd4);
        chk("multi_batches", 32'(stat_batches), 32'd2);

        // first-only
        drive(2, 20, 16'hFFFF, 5, 1'b1);
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        check_rec("first", 2, 21, 5, 1);
        step(1);
        chk("first_done_valid", 32'(out_valid), 32'd0);
        chk("first_hits", 32'(stat_hits), 32'd5);

        // backpressure, with a competing batch offered during the stall
        drive(2, 20, 16'hFFFF, 5, 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        step(1);
        drive(9, 0, 16'hFFFF, 0, 1'b0);
        check_rec("bp0", 2, 21, 5, 0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_rec("bp_stall", 2, 21, 5, 0);
            chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_batches", 32'(stat_batches), 32'd4);
        step(1);
        check_rec("bp1", 2, 24, 8, 0);
        step(1);
        check_rec("bp2", 2, 26, 6, 1);
        step(1);
        chk("bp_done_valid", 32'(out_valid), 32'd0);
        chk("bp_hits", 32'(stat_hits), 32'd8);
        chk("bp_batches_after", 32'(stat_batches), 32'd4);

        // empty batch: threshold above any possible score
        drive(2, 20, 16'hFFFF, 17, 1'b0);
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        chk("empty_valid", 32'(out_valid), 32'd0);
        chk("empty_in_ready", 32'(in_ready), 32'd1);
        chk("empty_count", 32'(stat_empty), 32'd1);
        chk("empty_batches", 32'(stat_batches), 32'd5);
        step(1);
        chk("empty_valid_later", 32'(out_valid), 32'd0);

        // threshold 0: every lane hits, first-only keeps lane 0 with score 0
        drive(3, 7, 16'h0000, 0, 1'b1);
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        check_rec("thr0", 3, 7, 0, 1);
        step(1);
        chk("thr0_hits", 32'(stat_hits), 32'd9);

        // column wrap-around: 62 + 3 mod 64 = 1
        in_weights = '0;
        in_weights[3*T +: T] = 16'h000F;
        drive(1, 62, 16'hFFFF, 1, 1'b0);
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        check_rec("wrap", 1, 1, 4, 1);
        step(1);
        chk("wrap_hits", 32'(stat_hits), 32'd10);
        chk("wrap_batches", 32'(stat_batches), 32'd7);

        // reset in the middle of a 3-record batch
        load_multi();
        drive(4, 30, 16'hFFFF, 5, 1'b0);
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        check_rec("rmid0", 4, 31, 5, 0);
        step(1);
        check_rec("rmid1", 4, 34, 8, 0);
        rst = 1'b1;
        #1;
        chk("rmid_valid", 32'(out_valid), 32'd0);
        chk("rmid_in_ready", 32'(in_ready), 32'd1);
        chk("rmid_batches", 32'(stat_batches), 32'd0);
        chk("rmid_hits", 32'(stat_hits), 32'd0);
        chk("rmid_empty", 32'(stat_empty), 32'd0);
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("rmid_no_residual", 32'(out_valid), 32'd0);
        end
        chk("rmid_in_ready_after", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
